// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: combinational one-hot ack, registered broadcast.
// Optional macro CDB_BRANCH_PRIORITY_EN restricts the search to taken-branch requesters when any exist.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_TAG_W = 5,
  localparam int unsigned PTR_W    = $clog2(NUM_FU)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      squash,
  input  logic                      cdb_stall,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]    fu_value,
  input  logic [NUM_FU-1:0]         fu_take_branch,
  input  logic [NUM_FU*XLEN-1:0]    fu_branch_loc,
  output logic [NUM_FU-1:0]         fu_ack,
  output logic                      cdb_valid,
  output logic [ROB_TAG_W-1:0]      cdb_rob_tag,
  output logic [XLEN-1:0]           cdb_value,
  output logic                      cdb_take_branch,
  output logic [XLEN-1:0]           cdb_branch_loc,
  output logic                      cdb_busy
);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NUM_FU-1:0] req;
  logic              grant;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  idx;

  always_comb begin
    req = fu_done;
`ifdef CDB_BRANCH_PRIORITY_EN
    if (|(fu_done & fu_take_branch)) begin
      req = fu_done & fu_take_branch;
    end
`endif
  end

  // First requester at or after the pointer, wrapping.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % NUM_FU);
      if (!grant && req[idx]) begin
        grant = 1'b1;
        win   = idx;
      end
    end
    if (!reset_n || squash || cdb_stall) begin
      grant = 1'b0;
    end
  end

  always_comb begin
    fu_ack = '0;
    ptr_d  = ptr_q;
    if (grant) begin
      fu_ack = NUM_FU'(1) << win;
      ptr_d  = (win == PTR_W'(NUM_FU - 1)) ? '0 : win + 1'b1;
    end
  end

  assign cdb_busy = |(fu_done & ~fu_ack);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q           <= '0;
      cdb_valid       <= 1'b0;
      cdb_rob_tag     <= '0;
      cdb_value       <= '0;
      cdb_take_branch <= 1'b0;
      cdb_branch_loc  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant) begin
        cdb_valid       <= 1'b1;
        cdb_rob_tag     <= fu_rob_tag[win*ROB_TAG_W +: ROB_TAG_W];
        cdb_value       <= fu_value[win*XLEN +: XLEN];
        cdb_take_branch <= fu_take_branch[win];
        cdb_branch_loc  <= fu_branch_loc[win*XLEN +: XLEN];
      end else begin
        // Idle, stall and squash all clear the bus so no stale packet is seen.
        cdb_valid       <= 1'b0;
        cdb_rob_tag     <= '0;
        cdb_value       <= '0;
        cdb_take_branch <= 1'b0;
        cdb_branch_loc  <= '0;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single Common Data Bus among NUM_FU functional units, ALU FUs included.
- Each FU holds a completed result with `done` high until it receives `ack`.
- The arbiter grants at most one FU per cycle, returns `ack` to it combinationally, and registers the winner's packet onto the CDB for one cycle.
- It sits between the FU output registers and the ROB/RS/map-table CDB consumers.

Parameters:
- NUM_FU, 4, number of requesting functional units (≥2)
- XLEN, 32, data width of value and branch target
- ROB_TAG_W, 5, ROB tag width
- PTR_W, $clog2(NUM_FU), round-robin pointer width (derived, not overridden)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- squash  in  1  synchronous flush from branch-mispredict recovery
- cdb_stall  in  1  consumers cannot accept a broadcast; no grant this cycle
- fu_done  in  NUM_FU  per-FU result-pending request
- fu_rob_tag  in  NUM_FU*ROB_TAG_W  packed per-FU ROB tags, FU i at [i*ROB_TAG_W +: ROB_TAG_W]
- fu_value  in  NUM_FU*XLEN  packed per-FU result values
- fu_take_branch  in  NUM_FU  per-FU resolved-taken flag
- fu_branch_loc  in  NUM_FU*XLEN  packed per-FU branch targets
- fu_ack  out  NUM_FU  one-hot grant, combinational, same cycle as request
- cdb_valid  out  1  registered broadcast valid
- cdb_rob_tag  out  ROB_TAG_W  registered broadcast tag
- cdb_value  out  XLEN  registered broadcast value
- cdb_take_branch  out  1  registered broadcast taken flag
- cdb_branch_loc  out  XLEN  registered broadcast branch target
- cdb_busy  out  1  combinational: at least one fu_done high and not granted this cycle (contention indicator)

Behaviour:
- Reset (reset_n low, asynchronous): cdb_valid, cdb_rob_tag, cdb_value, cdb_take_branch, cdb_branch_loc all 0; pointer 0. fu_ack is 0 while reset is asserted. Release is synchronous to clock.
- Grant eligibility: grants allowed only when reset_n=1, squash=0 and cdb_stall=0; otherwise fu_ack=0.
- Winner selection: when eligible, the winner is the first i with fu_done[i]=1, searching from ptr upward and wrapping NUM_FU-1 → 0. fu_ack has exactly that bit set. All-zero fu_done gives fu_ack=0.
- Pointer update: on a grant to i, ptr ← (i+1) mod NUM_FU at the next edge. With no grant, ptr holds. Wrap: a grant to NUM_FU-1 sets ptr to 0.
- Latency: request sampled at cycle t, ack in t, broadcast fields valid in t+1 (cdb_valid=1 for exactly one cycle per grant).
- Register update when no grant (idle, stall or squash): cdb_valid←0 and all other cdb_* fields←0. No stale data is ever driven.
- Squash: takes priority over everything. No ack that cycle; cdb_valid←0 next cycle; ptr holds.
- Stall: no ack, cdb_valid←0 next cycle, ptr holds. Requesting FUs keep fu_done high and are served after stall drops, in normal round-robin order.
- Back-to-back: a granted FU may present a new result (fu_done still high, new tag) the cycle after ack. It is eligible again but ranks last behind the other requesters.
- Fairness: with all NUM_FU requesting continuously, each FU is granted exactly once every NUM_FU cycles.
- Arbitration must not depend on fu_value/fu_branch_loc contents. Input X on non-requesting lanes must not propagate.

Optional Feature:
- Macro: CDB_BRANCH_PRIORITY_EN.
- Defined: among requesting FUs with fu_take_branch=1, the round-robin search runs over that subset only, so taken-branch results reach the ROB first for earlier recovery. If no requester has take_branch=1, normal round-robin applies. The pointer update rule is unchanged.
- Undefined: pure round-robin, fu_take_branch is only passed through.

Test Plan:
- Reset: hold reset_n=0 with fu_done=4'b1111 → fu_ack=0 and all cdb_* =0. Release at cycle 0 → fu_ack=4'b0001 in cycle 0; cdb_valid=1 with FU0's tag in cycle 1.
- Full contention: fu_done=4'b1111 held for 8 cycles, tags 3/7/11/15 → grant order FU0,1,2,3,0,1,2,3; cdb_rob_tag 3,7,11,15,3,7,11,15 one cycle later.
- Wrap: ptr=3, fu_done=4'b0101 → ack FU0 (4'b0001) first, then FU2; ptr=3 after FU2's grant.
- Stall/squash: fu_done=4'b0010 with cdb_stall=1 for 2 cycles → fu_ack=0 and cdb_valid=0 in both. Stall drops → ack FU1. Same sequence with squash → identical response.
- Single requester streaming: FU2 requests every cycle with tags 1,2,3 → acked every cycle; cdb_valid continuous 3 cycles carrying 1,2,3.
- With CDB_BRANCH_PRIORITY_EN: ptr=0, fu_done=4'b0110, fu_take_branch=4'b0100 → FU2 acked first, then FU1. Without the macro → FU1 first.
